// File: rtl/counter_monitor.sv
// Checks a free-running counter against an internal model of its next value.
// Tracks mismatches and wrap-arounds, and re-acquires lock after any error.
module counter_monitor #(
    parameter int WIDTH = 9,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mon_en,
    input  logic             err_clr,
    input  logic             ctr_enable,
    input  logic             ctr_clr,
    input  logic [WIDTH-1:0] count,
    output logic             locked,
    output logic [WIDTH-1:0] expected,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_count,
    output logic             wrap_pulse
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_TRACK   = 2'd2;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    logic [1:0]       state_q, state_d;
    logic             locked_q, locked_d;
    logic [WIDTH-1:0] expected_q, expected_d;
    logic             err_pulse_q, err_pulse_d;
    logic             err_sticky_q, err_sticky_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             wrap_pulse_q, wrap_pulse_d;

    // Clear dominates enable, exactly like the monitored counter.
    function automatic logic [WIDTH-1:0] next_val(input logic [WIDTH-1:0] v,
                                                  input logic en,
                                                  input logic clr);
        if (clr)
            return '0;
        else if (en)
            return v + WIDTH'(1);
        else
            return v;
    endfunction

    always_comb begin
        state_d      = state_q;
        expected_d   = expected_q;
        err_pulse_d  = 1'b0;
        wrap_pulse_d = 1'b0;
        err_sticky_d = err_sticky_q;
        err_count_d  = err_count_q;

        if (err_clr) begin
            err_sticky_d = 1'b0;
            err_count_d  = '0;
        end

        if (!mon_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ACQUIRE;
                ST_ACQUIRE: begin
                    expected_d = next_val(count, ctr_enable, ctr_clr);
                    state_d    = ST_TRACK;
                end
                ST_TRACK: begin
                    if (count == expected_q) begin
                        expected_d   = next_val(expected_q, ctr_enable, ctr_clr);
                        wrap_pulse_d = (expected_q == CNT_MAX) && ctr_enable && !ctr_clr;
                    end else begin
                        // A clear on the same edge restarts the tally at this error.
                        state_d      = ST_ACQUIRE;
                        err_pulse_d  = 1'b1;
                        err_sticky_d = 1'b1;
                        if (err_clr)
                            err_count_d = ERR_W'(1);
                        else if (err_count_q != ERR_MAX)
                            err_count_d = err_count_q + ERR_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        locked_d = (state_d == ST_TRACK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            locked_q     <= 1'b0;
            expected_q   <= '0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
            wrap_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            locked_q     <= locked_d;
            expected_q   <= expected_d;
            err_pulse_q  <= err_pulse_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
            wrap_pulse_q <= wrap_pulse_d;
        end
    end

    assign locked     = locked_q;
    assign expected   = expected_q;
    assign err_pulse  = err_pulse_q;
    assign err_sticky = err_sticky_q;
    assign err_count  = err_count_q;
    assign wrap_pulse = wrap_pulse_q;

endmodule

// File: tb/tb_counter_monitor.sv
// Directed bench for counter_monitor: a vector table for single-edge behaviour,
// followed by multi-cycle sequences driven from a behavioural counter.
module tb_counter_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mon_en = 1'b0;
    logic       err_clr = 1'b0;
    logic       ctr_enable = 1'b0;
    logic       ctr_clr = 1'b0;
    logic [8:0] count = '0;
    logic       locked;
    logic [8:0] expected;
    logic       err_pulse;
    logic       err_sticky;
    logic [7:0] err_count;
    logic       wrap_pulse;

    int n_tests = 0;
    int n_fail  = 0;
    logic [8:0] cnt = '0;

    counter_monitor #(.WIDTH(9), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .mon_en(mon_en), .err_clr(err_clr),
        .ctr_enable(ctr_enable), .ctr_clr(ctr_clr), .count(count),
        .locked(locked), .expected(expected), .err_pulse(err_pulse),
        .err_sticky(err_sticky), .err_count(err_count), .wrap_pulse(wrap_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       mon_en, err_clr, en, clr;
        logic [8:0] count;
        logic       locked;
        logic [8:0] expected;
        logic       pulse, sticky;
        logic [7:0] ecnt;
        logic       wrap;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // One edge of the behavioural counter; outputs are sampled 1 ns after the edge.
    task automatic tick(input logic en, input logic clr);
        ctr_enable = en;
        ctr_clr    = clr;
        count      = cnt;
        @(posedge clk);
        cnt = clr ? 9'd0 : (en ? cnt + 9'd1 : cnt);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mon_en = 1'b0;
        err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        #2;
    endtask

    initial begin
        int wraps, wrap_from, bad_exp, lost_lock, errs_seen, pulses;

        //             mon clr en  cc  count  lk  exp  pl st ecnt wr
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 9'd5,   1'b0, 9'd0,   1'b0, 1'b0, 8'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 9'd0,   1'b1, 9'd1,   1'b0, 1'b0, 8'd0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 9'd1,   1'b1, 9'd2,   1'b0, 1'b0, 8'd0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 9'd2,   1'b1, 9'd2,   1'b0, 1'b0, 8'd0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 9'd2,   1'b1, 9'd3,   1'b0, 1'b0, 8'd0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 9'd7,   1'b0, 9'd3,   1'b1, 1'b1, 8'd1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 9'd8,   1'b1, 9'd9,   1'b0, 1'b1, 8'd1, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 9'd9,   1'b1, 9'd10,  1'b0, 1'b0, 8'd0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 9'd10,  1'b1, 9'd0,   1'b0, 1'b0, 8'd0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 9'd5,   1'b0, 9'd0,   1'b1, 1'b1, 8'd1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 9'd6,   1'b0, 9'd0,   1'b0, 1'b1, 8'd1, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 9'd0,   1'b0, 9'd0,   1'b0, 1'b1, 8'd1, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 9'd510, 1'b1, 9'd511, 1'b0, 1'b1, 8'd1, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 9'd511, 1'b1, 9'd0,   1'b0, 1'b1, 8'd1, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 9'd0,   1'b1, 9'd0,   1'b0, 1'b1, 8'd1, 1'b0};

        // Reset state
        do_reset();
        chk("rst_locked", int'(locked), 0);
        chk("rst_expected", int'(expected), 0);
        chk("rst_err", int'({err_pulse, err_sticky, err_count}), 0);
        chk("rst_wrap", int'(wrap_pulse), 0);

        for (int i = 0; i < 15; i++) begin
            mon_en = vecs[i].mon_en;
            err_clr = vecs[i].err_clr;
            ctr_enable = vecs[i].en;
            ctr_clr = vecs[i].clr;
            count = vecs[i].count;
            @(posedge clk);
            #1;
            $display("[TB] vec %0d: count=%0d locked=%0d expected=%0d pulse=%0d sticky=%0d ecnt=%0d wrap=%0d",
                     i, count, locked, expected, err_pulse, err_sticky, err_count, wrap_pulse);
            chk($sformatf("vec%0d_locked", i), int'(locked), int'(vecs[i].locked));
            chk($sformatf("vec%0d_expected", i), int'(expected), int'(vecs[i].expected));
            chk($sformatf("vec%0d_pulse", i), int'(err_pulse), int'(vecs[i].pulse));
            chk($sformatf("vec%0d_sticky", i), int'(err_sticky), int'(vecs[i].sticky));
            chk($sformatf("vec%0d_ecnt", i), int'(err_count), int'(vecs[i].ecnt));
            chk($sformatf("vec%0d_wrap", i), int'(wrap_pulse), int'(vecs[i].wrap));
        end
        err_clr = 1'b0;

        // Fault-free run: clear, then 600 enabled edges
        do_reset();
        mon_en = 1'b1;
        cnt = 9'd0;
        tick(1'b0, 1'b1);
        chk("run_locked_edge1", int'(locked), 0);
        wraps = 0; wrap_from = -1; bad_exp = 0; lost_lock = 0; errs_seen = 0;
        for (int i = 0; i < 600; i++) begin
            logic [8:0] prev;
            prev = cnt;
            tick(1'b1, 1'b0);
            if (!locked) lost_lock++;
            if (expected != cnt) bad_exp++;
            if (err_pulse) errs_seen++;
            if (wrap_pulse) begin
                wraps++;
                wrap_from = int'(prev);
            end
        end
        $display("[TB] run600: wraps=%0d from=%0d bad_exp=%0d lost=%0d ecnt=%0d", wraps, wrap_from, bad_exp, lost_lock, err_count);
        chk("run_lost_lock", lost_lock, 0);
        chk("run_expected", bad_exp, 0);
        chk("run_err_pulses", errs_seen, 0);
        chk("run_err_count", int'(err_count), 0);
        chk("run_wraps", wraps, 1);
        chk("run_wrap_from", wrap_from, 511);

        // Enable paused for two edges at 100
        while (cnt != 9'd100) tick(1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b0);
            $display("[TB] pause %0d: expected=%0d err_pulse=%0d", i, expected, err_pulse);
            chk("pause_expected", int'(expected), 100);
            chk("pause_no_err", int'(err_pulse), 0);
        end
        tick(1'b1, 1'b0);
        chk("resume_expected", int'(expected), 101);
        tick(1'b1, 1'b0);
        chk("resume_locked", int'(locked), 1);
        chk("resume_ecnt", int'(err_count), 0);

        // Corruption 37 -> 40
        tick(1'b0, 1'b1);
        while (cnt != 9'd38) tick(1'b1, 1'b0);
        cnt = 9'd40;
        tick(1'b1, 1'b0);
        $display("[TB] corrupt: locked=%0d pulse=%0d sticky=%0d ecnt=%0d", locked, err_pulse, err_sticky, err_count);
        chk("corr_pulse", int'(err_pulse), 1);
        chk("corr_sticky", int'(err_sticky), 1);
        chk("corr_ecnt", int'(err_count), 1);
        chk("corr_locked", int'(locked), 0);
        tick(1'b1, 1'b0);
        chk("relock_locked", int'(locked), 1);
        chk("relock_pulse", int'(err_pulse), 0);
        chk("relock_expected", int'(expected), 42);
        errs_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b0);
            if (err_pulse || !locked) errs_seen++;
        end
        chk("relock_clean", errs_seen, 0);
        chk("relock_ecnt", int'(err_count), 1);

        // Clear and enable together at 511
        tick(1'b0, 1'b1);
        while (cnt != 9'd511) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        $display("[TB] clr@511: expected=%0d wrap=%0d pulse=%0d", expected, wrap_pulse, err_pulse);
        chk("clrmax_expected", int'(expected), 0);
        chk("clrmax_wrap", int'(wrap_pulse), 0);
        chk("clrmax_pulse", int'(err_pulse), 0);

        // Build err_count=3, then asynchronous reset mid-cycle
        for (int i = 0; i < 2; i++) begin
            cnt = cnt + 9'd5;
            tick(1'b1, 1'b0);
            tick(1'b1, 1'b0);
        end
        chk("pre_rst_ecnt", int'(err_count), 3);
        chk("pre_rst_locked", int'(locked), 1);
        #3;
        rst_n = 1'b0;
        #1;
        $display("[TB] async rst: locked=%0d expected=%0d ecnt=%0d", locked, expected, err_count);
        chk("arst_locked", int'(locked), 0);
        chk("arst_expected", int'(expected), 0);
        chk("arst_err", int'({err_pulse, err_sticky, err_count}), 0);
        chk("arst_wrap", int'(wrap_pulse), 0);
        #2;
        rst_n = 1'b1;
        cnt = 9'd50;
        tick(1'b1, 1'b0);
        chk("arst_edge1_locked", int'(locked), 0);
        tick(1'b1, 1'b0);
        chk("arst_edge2_locked", int'(locked), 1);
        chk("arst_edge2_expected", int'(expected), 52);

        // Saturation: count stuck at 0 while enabled
        pulses = 0;
        for (int i = 0; i < 520; i++) begin
            cnt = 9'd0;
            tick(1'b1, 1'b0);
            if (err_pulse) pulses++;
        end
        $display("[TB] saturate: pulses=%0d ecnt=%0d sticky=%0d", pulses, err_count, err_sticky);
        chk("sat_pulses", pulses, 260);
        chk("sat_ecnt", int'(err_count), 255);
        chk("sat_sticky", int'(err_sticky), 1);
        chk("sat_locked", int'(locked), 1);
        err_clr = 1'b1;
        cnt = 9'd0;
        tick(1'b1, 1'b0);
        err_clr = 1'b0;
        $display("[TB] clr+err: ecnt=%0d sticky=%0d pulse=%0d", err_count, err_sticky, err_pulse);
        chk("clrerr_ecnt", int'(err_count), 1);
        chk("clrerr_sticky", int'(err_sticky), 1);
        chk("clrerr_pulse", int'(err_pulse), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
